// File: rtl/emotion_update_controller.sv
// Periodic sequencer for the combinational emotional_model classifier: quantizes drive
// levels on each tick, waits a settle window, then debounces the resulting emotion code.
module emotion_update_controller #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned HOLD_TICKS    = 2,
  parameter logic [7:0]  TH1           = 8'd64,
  parameter logic [7:0]  TH2           = 8'd128,
  parameter logic [7:0]  TH3           = 8'd192,
  parameter logic [7:0]  RESET_EMOTION = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] energy_lvl,
  input  logic [7:0] stress_lvl,
  input  logic [7:0] pleasure_lvl,
  input  logic [1:0] physical_state,
  output logic [1:0] model_energy,
  output logic [1:0] model_stress,
  output logic [1:0] model_pleasure,
  output logic [1:0] model_physical_state,
  input  logic [7:0] model_emotion,
  output logic [7:0] emotion,
  output logic       emotion_changed,
  output logic       busy,
  output logic       tick_overrun
);

  // Handshake: tick is a one-cycle strobe accepted only in IDLE; a tick seen while
  // busy is dropped and reported by a one-cycle tick_overrun pulse on the next cycle.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] HOLD_LIM    = 5'(HOLD_TICKS);

  state_t     state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [3:0] stable_cnt_q, stable_cnt_d;
  logic [7:0] candidate_q, candidate_d;
  logic [7:0] emotion_q, emotion_d;
  logic       emotion_changed_q, emotion_changed_d;
  logic       busy_q, busy_d;
  logic       tick_overrun_q, tick_overrun_d;
  logic [1:0] model_energy_q, model_energy_d;
  logic [1:0] model_stress_q, model_stress_d;
  logic [1:0] model_pleasure_q, model_pleasure_d;
  logic [1:0] model_phys_q, model_phys_d;
  logic [4:0] cnt_inc;

  function automatic logic [1:0] quantize(input logic [7:0] lvl);
    logic [1:0] q;
    q = 2'(lvl >= TH1) + 2'(lvl >= TH2) + 2'(lvl >= TH3);
    return q;
  endfunction

  assign cnt_inc = {1'b0, stable_cnt_q} + 5'd1;

  always_comb begin
    state_d           = state_q;
    settle_cnt_d      = settle_cnt_q;
    stable_cnt_d      = stable_cnt_q;
    candidate_d       = candidate_q;
    emotion_d         = emotion_q;
    emotion_changed_d = 1'b0;
    model_energy_d    = model_energy_q;
    model_stress_d    = model_stress_q;
    model_pleasure_d  = model_pleasure_q;
    model_phys_d      = model_phys_q;
    tick_overrun_d    = tick && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          model_energy_d   = quantize(energy_lvl);
          model_stress_d   = quantize(stress_lvl);
          model_pleasure_d = quantize(pleasure_lvl);
          model_phys_d     = physical_state;
          settle_cnt_d     = SETTLE_INIT;
          state_d          = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 4'd0) state_d = ST_EVAL;
        else settle_cnt_d = settle_cnt_q - 4'd1;
      end
      ST_EVAL: begin
        state_d = ST_IDLE;
        if (model_emotion == emotion_q) begin
          // Classifier agrees with the committed code: drop any pending change.
          candidate_d  = emotion_q;
          stable_cnt_d = 4'd0;
        end else if (model_emotion == candidate_q) begin
          if (cnt_inc >= HOLD_LIM) begin
            emotion_d         = model_emotion;
            emotion_changed_d = 1'b1;
            stable_cnt_d      = 4'd0;
          end else begin
            stable_cnt_d = cnt_inc[3:0];
          end
        end else begin
          candidate_d = model_emotion;
          if (HOLD_LIM <= 5'd1) begin
            emotion_d         = model_emotion;
            emotion_changed_d = 1'b1;
            stable_cnt_d      = 4'd0;
          end else begin
            stable_cnt_d = 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      settle_cnt_q      <= 4'd0;
      stable_cnt_q      <= 4'd0;
      candidate_q       <= RESET_EMOTION;
      emotion_q         <= RESET_EMOTION;
      emotion_changed_q <= 1'b0;
      busy_q            <= 1'b0;
      tick_overrun_q    <= 1'b0;
      model_energy_q    <= 2'd0;
      model_stress_q    <= 2'd0;
      model_pleasure_q  <= 2'd0;
      model_phys_q      <= 2'd0;
    end else begin
      state_q           <= state_d;
      settle_cnt_q      <= settle_cnt_d;
      stable_cnt_q      <= stable_cnt_d;
      candidate_q       <= candidate_d;
      emotion_q         <= emotion_d;
      emotion_changed_q <= emotion_changed_d;
      busy_q            <= busy_d;
      tick_overrun_q    <= tick_overrun_d;
      model_energy_q    <= model_energy_d;
      model_stress_q    <= model_stress_d;
      model_pleasure_q  <= model_pleasure_d;
      model_phys_q      <= model_phys_d;
    end
  end

  assign model_energy         = model_energy_q;
  assign model_stress         = model_stress_q;
  assign model_pleasure       = model_pleasure_q;
  assign model_physical_state = model_phys_q;
  assign emotion              = emotion_q;
  assign emotion_changed      = emotion_changed_q;
  assign busy                 = busy_q;
  assign tick_overrun         = tick_overrun_q;

endmodule

// File: tb/tb_emotion_update_controller.sv
// Directed bench for emotion_update_controller: default instance plus a SETTLE_CYCLES=4
// instance used for the mid-settle reset scenario.
module tb_emotion_update_controller;

  logic       clk = 1'b0;
  logic       rst, rst4, tick;
  logic [7:0] energy_lvl, stress_lvl, pleasure_lvl, model_emotion;
  logic [1:0] physical_state;

  logic [1:0] model_energy, model_stress, model_pleasure, model_physical_state;
  logic [7:0] emotion;
  logic       emotion_changed, busy, tick_overrun;

  logic [1:0] model_energy_4, model_stress_4, model_pleasure_4, model_physical_state_4;
  logic [7:0] emotion_4;
  logic       emotion_changed_4, busy_4, tick_overrun_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  emotion_update_controller dut (
    .clk(clk), .rst(rst), .tick(tick),
    .energy_lvl(energy_lvl), .stress_lvl(stress_lvl), .pleasure_lvl(pleasure_lvl),
    .physical_state(physical_state),
    .model_energy(model_energy), .model_stress(model_stress),
    .model_pleasure(model_pleasure), .model_physical_state(model_physical_state),
    .model_emotion(model_emotion), .emotion(emotion), .emotion_changed(emotion_changed),
    .busy(busy), .tick_overrun(tick_overrun)
  );

  emotion_update_controller #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .tick(tick),
    .energy_lvl(energy_lvl), .stress_lvl(stress_lvl), .pleasure_lvl(pleasure_lvl),
    .physical_state(physical_state),
    .model_energy(model_energy_4), .model_stress(model_stress_4),
    .model_pleasure(model_pleasure_4), .model_physical_state(model_physical_state_4),
    .model_emotion(model_emotion), .emotion(emotion_4), .emotion_changed(emotion_changed_4),
    .busy(busy_4), .tick_overrun(tick_overrun_4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one tick with the given levels; returns just after the sampling edge.
  task automatic send_tick(input logic [7:0] e, input logic [7:0] s, input logic [7:0] p,
                           input logic [1:0] ps);
    energy_lvl = e; stress_lvl = s; pleasure_lvl = p; physical_state = ps;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (emotion !== 8'h00) begin errors++; $display("FAIL rst_emotion got %0h exp 00", emotion); end
    checks++; if ({model_energy, model_stress, model_pleasure, model_physical_state} !== 8'h00) begin
      errors++; $display("FAIL rst_model got %0h exp 00",
                         {model_energy, model_stress, model_pleasure, model_physical_state}); end
    checks++; if ({busy, emotion_changed, tick_overrun} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b exp 000", {busy, emotion_changed, tick_overrun}); end
    step();
    checks++; if ({busy, emotion_changed, tick_overrun, emotion} !== 11'h000) begin
      errors++; $display("FAIL rst_idle got %0h exp 000", {busy, emotion_changed, tick_overrun, emotion}); end
  endtask

  task automatic test_quantize();
    model_emotion = 8'h00;
    send_tick(8'd63, 8'd255, 8'd0, 2'd2);
    checks++; if ({model_energy, model_stress, model_pleasure, model_physical_state} !== 8'b00_11_00_10) begin
      errors++; $display("FAIL quant_63 got %b exp 00110010",
                         {model_energy, model_stress, model_pleasure, model_physical_state}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL quant_busy got %b exp 1", busy); end
    step(); step();
    send_tick(8'd64, 8'd128, 8'd127, 2'd1);
    checks++; if ({model_energy, model_stress, model_pleasure, model_physical_state} !== 8'b01_10_01_01) begin
      errors++; $display("FAIL quant_64 got %b exp 01100101",
                         {model_energy, model_stress, model_pleasure, model_physical_state}); end
    step(); step();
    send_tick(8'd191, 8'd0, 8'd0, 2'd0);
    checks++; if (model_energy !== 2'd2) begin errors++; $display("FAIL quant_191 got %0d exp 2", model_energy); end
    step(); step();
    send_tick(8'd192, 8'd0, 8'd0, 2'd3);
    checks++; if (model_energy !== 2'd3) begin errors++; $display("FAIL quant_192 got %0d exp 3", model_energy); end
    energy_lvl = 8'd0; physical_state = 2'd0;
    step(); step(); step(); step();
    checks++; if ({model_energy, model_physical_state} !== 4'b1111) begin
      errors++; $display("FAIL quant_hold got %b exp 1111", {model_energy, model_physical_state}); end
    checks++; if ({emotion, emotion_changed} !== 9'h000) begin
      errors++; $display("FAIL quant_nocommit got %0h exp 000", {emotion, emotion_changed}); end
  endtask

  task automatic test_debounce();
    model_emotion = 8'h21;
    send_tick(8'd10, 8'd10, 8'd10, 2'd0);
    step(); step();
    checks++; if ({emotion, emotion_changed, busy} !== 10'h000) begin
      errors++; $display("FAIL dbn_tick1 got %0h exp 000", {emotion, emotion_changed, busy}); end
    send_tick(8'd10, 8'd10, 8'd10, 2'd0);
    step();
    checks++; if ({emotion, emotion_changed} !== 9'h000) begin
      errors++; $display("FAIL dbn_early got %0h exp 000", {emotion, emotion_changed}); end
    step();
    checks++; if ({emotion, emotion_changed} !== {8'h21, 1'b1}) begin
      errors++; $display("FAIL dbn_commit got %0h exp 43", {emotion, emotion_changed}); end
    step();
    checks++; if ({emotion, emotion_changed} !== {8'h21, 1'b0}) begin
      errors++; $display("FAIL dbn_pulse got %0h exp 42", {emotion, emotion_changed}); end
  endtask

  task automatic test_cancel();
    model_emotion = 8'h35;
    send_tick(8'd0, 8'd0, 8'd0, 2'd0); step(); step();
    model_emotion = 8'h21;
    send_tick(8'd0, 8'd0, 8'd0, 2'd0); step(); step();
    checks++; if ({emotion, emotion_changed} !== {8'h21, 1'b0}) begin
      errors++; $display("FAIL cancel_back got %0h exp 42", {emotion, emotion_changed}); end
    model_emotion = 8'h35;
    send_tick(8'd0, 8'd0, 8'd0, 2'd0); step(); step();
    checks++; if ({emotion, emotion_changed} !== {8'h21, 1'b0}) begin
      errors++; $display("FAIL cancel_restart got %0h exp 42", {emotion, emotion_changed}); end
    send_tick(8'd0, 8'd0, 8'd0, 2'd0); step(); step();
    checks++; if ({emotion, emotion_changed} !== {8'h35, 1'b1}) begin
      errors++; $display("FAIL cancel_commit got %0h exp 6b", {emotion, emotion_changed}); end
  endtask

  task automatic test_overrun();
    send_tick(8'd200, 8'd0, 8'd0, 2'd1);
    energy_lvl = 8'd10; physical_state = 2'd2; tick = 1'b1;
    step();
    tick = 1'b0;
    checks++; if ({tick_overrun, busy} !== 2'b11) begin
      errors++; $display("FAIL ovr_pulse got %b exp 11", {tick_overrun, busy}); end
    checks++; if ({model_energy, model_physical_state} !== 4'b1101) begin
      errors++; $display("FAIL ovr_model got %b exp 1101", {model_energy, model_physical_state}); end
    step();
    checks++; if ({tick_overrun, busy, emotion_changed, emotion} !== {3'b000, 8'h35}) begin
      errors++; $display("FAIL ovr_done got %0h exp 035", {tick_overrun, busy, emotion_changed, emotion}); end
    send_tick(8'd70, 8'd0, 8'd0, 2'd0);
    checks++; if ({model_energy, busy, tick_overrun} !== 4'b0110) begin
      errors++; $display("FAIL b2b_accept got %b exp 0110", {model_energy, busy, tick_overrun}); end
    step(); step();
  endtask

  task automatic test_reset_mid_settle();
    int seen;
    rst4 = 1'b0;
    model_emotion = 8'h44;
    send_tick(8'd0, 8'd0, 8'd0, 2'd0);
    step(); step(); step(); step();
    checks++; if ({busy_4, emotion_4} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL s4_settle got %0h exp 100", {busy_4, emotion_4}); end
    step();
    checks++; if ({busy_4, emotion_changed_4, emotion_4} !== 10'h000) begin
      errors++; $display("FAIL s4_pending got %0h exp 000", {busy_4, emotion_changed_4, emotion_4}); end
    send_tick(8'd255, 8'd0, 8'd0, 2'd0);
    step();
    checks++; if ({busy_4, model_energy_4} !== 3'b111) begin
      errors++; $display("FAIL s4_pre_rst got %b exp 111", {busy_4, model_energy_4}); end
    rst4 = 1'b1; step(); rst4 = 1'b0;
    checks++; if ({busy_4, emotion_changed_4, model_energy_4, emotion_4} !== 12'h000) begin
      errors++; $display("FAIL s4_rst got %0h exp 000",
                         {busy_4, emotion_changed_4, model_energy_4, emotion_4}); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(); if (emotion_changed_4 || busy_4) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL s4_quiet got %0d exp 0", seen); end
    send_tick(8'd0, 8'd0, 8'd0, 2'd0);
    step(); step(); step(); step(); step();
    checks++; if ({emotion_changed_4, emotion_4} !== 9'h000) begin
      errors++; $display("FAIL s4_clean got %0h exp 000", {emotion_changed_4, emotion_4}); end
    send_tick(8'd0, 8'd0, 8'd0, 2'd0);
    step(); step(); step(); step();
    checks++; if (emotion_4 !== 8'h00) begin errors++; $display("FAIL s4_lat got %0h exp 00", emotion_4); end
    step();
    checks++; if ({emotion_4, emotion_changed_4} !== {8'h44, 1'b1}) begin
      errors++; $display("FAIL s4_commit got %0h exp 89", {emotion_4, emotion_changed_4}); end
  endtask

  initial begin
    tick = 1'b0; rst = 1'b1; rst4 = 1'b1;
    energy_lvl = 8'd0; stress_lvl = 8'd0; pleasure_lvl = 8'd0;
    physical_state = 2'd0; model_emotion = 8'h00;
    test_reset();
    test_quantize();
    test_debounce();
    test_cancel();
    test_overrun();
    test_reset_mid_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
